// File: rtl/pipelined_mux_scanner_pkg.sv
// rtl/pipelined_mux_scanner_pkg.sv - shared constants for the pipelined mux scanner
package pipelined_mux_scanner_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/pipelined_mux_scanner_mux_tree_level.sv
// rtl/pipelined_mux_scanner_mux_tree_level.sv - one registered 2:1 reduction level of the mux tree
module mux_tree_level
    import pipelined_mux_scanner_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3,
    parameter int BIT   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [N_IN*WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic [SEL_W-1:0]              in_tag,
    output logic [(N_IN/2)*WIDTH-1:0]     out_data,
    output logic                          out_valid,
    output logic [SEL_W-1:0]              out_tag
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] data_d, data_q;
    logic                   valid_d, valid_q;
    logic [SEL_W-1:0]       tag_d, tag_q;

    // The full select travels as the tag: it is both the channel index and the remaining select bits.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        if (en) begin
            for (int j = 0; j < N_OUT; j++) begin
                data_d[j*WIDTH +: WIDTH] = in_tag[BIT] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                                                       : in_data[(2*j)*WIDTH +: WIDTH];
            end
            valid_d = in_valid;
            tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/pipelined_mux_scanner.sv
// rtl/pipelined_mux_scanner.sv - N:1 pipelined mux tree with valid tag, stall and round-robin scan
module pipelined_mux_scanner
    import pipelined_mux_scanner_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    scan_clr,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_ch,
    output logic [SEL_W-1:0]        scan_ch
);

    localparam int LEVELS = SEL_W;

    logic [SEL_W-1:0] scan_d, scan_q;
    logic [SEL_W-1:0] eff_sel;
    logic             scan_accept;

    assign scan_accept = en && (mode == MODE_SCAN) && in_valid;

    // A clear colliding with an accepted scan sample hands that sample channel 0.
    always_comb begin
        eff_sel = sel;
        if (mode == MODE_SCAN) begin
            eff_sel = scan_clr ? '0 : scan_q;
        end
    end

    always_comb begin
        scan_d = scan_q;
        if (scan_clr) begin
            scan_d = scan_accept ? SEL_W'(1) : '0;
        end else if (scan_accept) begin
            scan_d = scan_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    assign scan_ch = scan_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = NUM_IN >> k;

        logic [NI*WIDTH-1:0]     lin_data;
        logic                    lin_valid;
        logic [SEL_W-1:0]        lin_tag;
        logic [(NI/2)*WIDTH-1:0] lout_data;
        logic                    lout_valid;
        logic [SEL_W-1:0]        lout_tag;

        if (k == 0) begin : g_first
            assign lin_data  = in_data;
            assign lin_valid = in_valid;
            assign lin_tag   = eff_sel;
        end else begin : g_next
            assign lin_data  = g_lvl[k-1].lout_data;
            assign lin_valid = g_lvl[k-1].lout_valid;
            assign lin_tag   = g_lvl[k-1].lout_tag;
        end

        mux_tree_level #(
            .WIDTH (WIDTH),
            .N_IN  (NI),
            .SEL_W (SEL_W),
            .BIT   (k)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_data   (lin_data),
            .in_valid  (lin_valid),
            .in_tag    (lin_tag),
            .out_data  (lout_data),
            .out_valid (lout_valid),
            .out_tag   (lout_tag)
        );
    end

    assign out_data  = g_lvl[LEVELS-1].lout_data;
    assign out_valid = g_lvl[LEVELS-1].lout_valid;
    assign out_ch    = g_lvl[LEVELS-1].lout_tag;

endmodule

// File: tb/tb_pipelined_mux_scanner.sv
// tb/tb_pipelined_mux_scanner.sv - table, sequence and random checks of pipelined_mux_scanner
module tb_pipelined_mux_scanner;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int LV = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic           in_valid, en, mode, scan_clr;
    logic [2:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [2:0]     out_ch, scan_ch;

    logic [31:0] in_data2;
    logic        in_valid2, en2;
    logic [0:0]  sel2;
    logic [15:0] out_data2;
    logic        out_valid2;
    logic [0:0]  out_ch2, scan_ch2;

    pipelined_mux_scanner #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .scan_clr  (scan_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .scan_ch   (scan_ch)
    );

    pipelined_mux_scanner #(.WIDTH(16), .NUM_IN(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .en        (en2),
        .mode      (1'b0),
        .sel       (sel2),
        .scan_clr  (1'b0),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_ch    (out_ch2),
        .scan_ch   (scan_ch2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [2:0] ch;
    } smp_t;

    smp_t hist[$];
    int   scan_m;

    typedef struct {
        logic       e, v, m;
        logic [2:0] s;
        logic       c;
        logic       xv;
        logic [7:0] xd;
        logic [2:0] xch, xscan;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        scan_m = 0;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'hA0 + 8'(k);
    endtask

    // Model: each enabled edge appends the chosen sample; the output is the one LV enabled edges back.
    task automatic apply(input logic e, input logic v, input logic m, input logic [2:0] s, input logic c);
        int ch;
        en = e; in_valid = v; mode = m; sel = s; scan_clr = c;
        @(posedge clk);
        #1;
        if (e) begin
            ch = m ? (c ? 0 : scan_m) : int'(s);
            hist.push_back({v, in_data[ch*W +: W], 3'(ch)});
        end
        if (c) scan_m = (e && m && v) ? 1 : 0;
        else if (e && m && v) scan_m = (scan_m + 1) % N;
    endtask

    task automatic check_model(input string tag);
        smp_t x;
        x = '0;
        if (hist.size() >= LV) x = hist[hist.size() - LV];
        chk({tag, "_scan_ch"}, 32'(scan_ch), 32'(scan_m));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(x.v));
        if (x.v) begin
            chk({tag, "_out_data"}, 32'(out_data), 32'(x.d));
            chk({tag, "_out_ch"}, 32'(out_ch), 32'(x.ch));
        end
    endtask

    task automatic step(input logic e, input logic v, input logic m, input logic [2:0] s, input logic c,
                        input string tag);
        apply(e, v, m, s, c);
        check_model(tag);
    endtask

    task automatic do_reset();
        en = 1'b0; in_valid = 1'b0; mode = 1'b0; sel = '0; scan_clr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int sidx, chs;
        rst_n = 1'b1;
        en = 1'b0; in_valid = 1'b0; mode = 1'b0; sel = '0; scan_clr = 1'b0;
        en2 = 1'b0; in_valid2 = 1'b0; sel2 = '0; in_data2 = '0;
        set_ramp();
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_ch", 32'(out_ch), 0);
        chk("reset_scan_ch", 32'(scan_ch), 0);
        chk("reset_out_valid2", 32'(out_valid2), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();

        // Direct sweep 0..7, then ten scan samples wrapping past 7, then two bubbles.
        for (int r = 0; r < 20; r++) begin
            tbl[r].e = 1'b1;
            tbl[r].v = (r < 18);
            tbl[r].m = (r >= 8);
            tbl[r].s = (r < 8) ? 3'(r) : 3'd0;
            tbl[r].c = 1'b0;
            sidx = r - 2;
            tbl[r].xv = (sidx >= 0) && (sidx < 18);
            chs = (sidx < 8) ? sidx : (sidx - 8) % 8;
            if (chs < 0) chs = 0;
            tbl[r].xch = 3'(chs);
            tbl[r].xd = 8'hA0 + 8'(chs);
            tbl[r].xscan = (r < 8) ? 3'd0 : (r < 18) ? 3'((r - 7) % 8) : 3'd2;
        end
        for (int r = 0; r < 20; r++) begin
            apply(tbl[r].e, tbl[r].v, tbl[r].m, tbl[r].s, tbl[r].c);
            chk($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].xv));
            chk($sformatf("tbl%0d_scan", r), 32'(scan_ch), 32'(tbl[r].xscan));
            if (tbl[r].xv) begin
                chk($sformatf("tbl%0d_data", r), 32'(out_data), 32'(tbl[r].xd));
                chk($sformatf("tbl%0d_ch", r), 32'(out_ch), 32'(tbl[r].xch));
            end
        end

        // Stall for two cycles, then a bubble, in scan mode.
        do_reset();
        set_ramp();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, "pre_stall");
        step(0, 1, 1, 0, 0, "stall");
        step(0, 1, 1, 0, 0, "stall");
        chk("stall_scan_hold", 32'(scan_ch), 3);
        step(1, 0, 1, 0, 0, "bubble");
        chk("bubble_scan_hold", 32'(scan_ch), 3);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, "post_bubble");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, "flush");

        // Clear colliding with an accepted scan sample at scan_ch = 5.
        do_reset();
        set_ramp();
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, "to5");
        chk("clr_pre_scan", 32'(scan_ch), 5);
        step(1, 1, 1, 0, 1, "clr");
        chk("clr_next_scan", 32'(scan_ch), 1);
        step(1, 0, 1, 0, 0, "clr_f");
        step(1, 0, 1, 0, 0, "clr_f");
        chk("clr_out_valid", 32'(out_valid), 1);
        chk("clr_out_ch", 32'(out_ch), 0);
        chk("clr_out_data", 32'(out_data), 32'h A0);

        // Asynchronous reset with samples in flight.
        do_reset();
        set_ramp();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, "flight");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_out_ch", 32'(out_ch), 0);
        chk("midrst_scan_ch", 32'(scan_ch), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 3'd2, 0, "post_rst");

        // Two-input, 16-bit variant: one cycle of latency.
        in_data2 = {16'hBEEF, 16'h1234};
        en2 = 1'b1; in_valid2 = 1'b1; sel2 = 1'b1;
        @(posedge clk); #1;
        chk("v2_data_ch1", 32'(out_data2), 32'hBEEF);
        chk("v2_valid", 32'(out_valid2), 1);
        chk("v2_ch1", 32'(out_ch2), 1);
        sel2 = 1'b0;
        @(posedge clk); #1;
        chk("v2_data_ch0", 32'(out_data2), 32'h1234);
        chk("v2_ch0", 32'(out_ch2), 0);
        en2 = 1'b0; in_data2 = 32'h5555_AAAA; sel2 = 1'b1;
        @(posedge clk); #1;
        chk("v2_stall_data", 32'(out_data2), 32'h1234);
        chk("v2_scan_ch", 32'(scan_ch2), 0);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            in_data = {$urandom(), $urandom()};
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 (i / 100) % 3 != 0 ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_mux_scanner.md
Name: pipelined_mux_scanner

Overview:
- Parametrised N:1 multiplexer for WIDTH-bit buses, built as a binary tree of 2:1 mux levels with one register stage per level.
- Adds a valid tag, a stall enable and an auto-scan mode in which an internal channel counter round-robins through the inputs.
- Sits between a bank of parallel data sources and a single downstream consumer, for example a shared serialiser or monitor port.

Parameters:
- WIDTH, 8: bit width of each input channel and of the output.
- NUM_IN, 8: number of input channels. Must be a power of 2, minimum 2.
- SEL_W, $clog2(NUM_IN): select width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  1  presented sample is valid
- en  input  1  pipeline advance; 0 holds every stage
- mode  input  1  0 = direct (use sel), 1 = scan (use internal counter)
- sel  input  SEL_W  channel select in direct mode
- scan_clr  input  1  synchronous clear of the scan counter
- out_data  output  WIDTH  selected channel, delayed
- out_valid  output  1  out_data is valid
- out_ch  output  SEL_W  channel index that produced out_data
- scan_ch  output  SEL_W  current scan counter value

Behaviour:
- Tree structure:
  - LEVELS = SEL_W.
  - Level 0 pairs channels (2j, 2j+1) using effective-select bit 0.
  - Level k uses effective-select bit k.
  - The final level yields one word.
  - LSB selects first, so eff_sel = 3 picks channel 3.
- Effective select: eff_sel = mode ? scan_ch : sel, sampled in the same cycle as in_data.
- Accept: a sample is accepted when en=1. Each register level captures data, valid, and the channel index plus the remaining select bits.
- Latency: exactly LEVELS enabled cycles from acceptance to out_data/out_valid/out_ch. Throughput is one sample per enabled cycle.
- Stall: with en=0, every stage register holds, outputs hold, and the scan counter holds.
- Bubbles: in_valid=0 with en=1 propagates a bubble (valid=0). Data registers still load; their contents are don't-care.
- Scan counter:
  - With en=1, mode=1 and in_valid=1, scan_ch increments after use.
  - Wrap: NUM_IN-1 -> 0.
  - With in_valid=0, the counter does not advance, so no channel is skipped.
  - In mode=0 the counter holds its value. Switching back to mode=1 resumes from the held value.
- scan_clr:
  - Takes effect regardless of en.
  - If the same cycle is an accepted scan sample, that sample uses channel 0 and the counter becomes 1.
  - Otherwise the counter becomes 0.
- Direct mode: sel is unchecked; every SEL_W value is legal.
- Reset (asynchronous assert, release synchronised externally):
  - All valid bits, out_valid, out_data, out_ch and scan_ch go to 0.
  - In-flight samples are discarded.
  - The first output after reset is valid no earlier than LEVELS cycles after the first accepted sample.
- Mid-flight mode or sel changes affect only newly accepted samples; samples already in the pipe keep their captured select.

Decomposition:
- Shared package:
  - MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
  - A clog2 helper, if the toolchain lacks $clog2.
- Sub-module mux_tree_level: one registered tree level.
  - Parameters: WIDTH, N_IN (inputs at that level).
  - Performs N_IN/2 2:1 selections on a given select bit.
  - Registers data, valid and the select/channel tag, with en hold and rst_n clear.
  - The top level instantiates it LEVELS times in a generate loop.
  - The top level also owns the scan counter.

Test Plan:
- Direct sweep (WIDTH=8, NUM_IN=8):
  - Stimulus: in_data channel k = 8'hA0+k; sel=0..7 on consecutive cycles, en=1, in_valid=1.
  - Response: 3 cycles later out_data = A0..A7 on consecutive cycles, out_ch = 0..7, out_valid high throughout.
- Scan wrap:
  - Stimulus: mode=1, same data, 10 consecutive valid cycles.
  - Response: out_data sequence A0..A7,A0,A1; scan_ch wraps 7->0.
- Stall and bubble:
  - Stimulus: en=0 for 2 cycles mid-stream, then in_valid=0 for 1 cycle in scan mode.
  - Response: outputs frozen during the stall; one out_valid=0 bubble; scan sequence continues without skipping a channel.
- scan_clr collision:
  - Stimulus: scan_ch=5, scan_clr=1 together with an accepted sample.
  - Response: that sample yields out_ch=0 / A0; next scan_ch=1.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 asynchronously with 3 samples in flight.
  - Response: out_valid, out_data, out_ch and scan_ch go to 0 immediately; no stale sample emerges after release.
- Parameter variant:
  - Configuration: NUM_IN=2, WIDTH=16.
  - Response: latency is 1 cycle; sel=1 passes channel 1 unchanged.
